// File: rtl/uart_pkg.sv
`default_nettype none
//============================================================================
// Package : uart_pkg
// Shared UART receiver types, sample points and baud divider helper.
// Rev     : 1.0
//============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BRK
  } rx_state_t;

  localparam logic [3:0] RX_MID_SAMPLE  = 4'd7;
  localparam logic [3:0] RX_LAST_SAMPLE = 4'd15;

  // Clocks per 1/16-bit tick, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud * 8) / (baud * 16);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
//============================================================================
// Module : sync_fifo
// First-word-fall-through synchronous FIFO, power-of-two depth.
// Rev    : 1.0
//============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]  r_wr_ptr;
  logic [PTRW-1:0]  r_rd_ptr;
  logic [CNTW-1:0]  r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNTW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop && !empty;
  // A pop frees the head slot in the same clk, so a full FIFO still accepts.
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTRW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTRW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
//============================================================================
// Module : uart_rx_fifo
// 8N1 UART receiver, 16x oversampled, glitch/framing checks, FWFT FIFO.
// Rev    : 1.0
//============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            uart_rx,
  input  logic                            rd_en,
  output logic [7:0]                      rd_data,
  output logic                            rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            rx_busy,
  output logic                            frame_err,
  output logic                            overflow,
  input  logic                            clear_err
);

  localparam int DIV  = calc_div(CLK_HZ, BAUD);
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (DIV < 1) begin : g_bad_div
      $error("uart_rx_fifo: baud divider evaluates below 1");
    end
    if (OVERSAMPLE != 16) begin : g_bad_oversample
      $error("uart_rx_fifo: only 16x oversampling is supported");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end
  endgenerate

  logic            r_sync1;
  logic            r_sync2;
  logic            w_rx_s;
  logic [DIVW-1:0] r_div;
  logic            w_tick;
  rx_state_t       r_state;
  logic [3:0]      r_scnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_push;
  logic            r_frame_err;
  logic            r_overflow;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rx_s = r_sync2;

  assign w_tick = (r_div == DIVW'(DIV - 1));
  always_ff @(posedge clk) begin
    if (rst || w_tick) r_div <= '0;
    else               r_div <= r_div + DIVW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RX_IDLE;
      r_scnt      <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (clear_err) r_frame_err <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (w_tick && !w_rx_s) begin
            r_state <= RX_START;
            r_scnt  <= '0;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_scnt == RX_MID_SAMPLE) begin
              if (w_rx_s) begin
                r_state <= RX_IDLE;
              end else begin
                r_state   <= RX_DATA;
                r_scnt    <= '0;
                r_bit_idx <= '0;
              end
            end else begin
              r_scnt <= r_scnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            if (r_scnt == RX_LAST_SAMPLE) begin
              r_shift <= {w_rx_s, r_shift[7:1]};
              r_scnt  <= '0;
              if (r_bit_idx == 3'd7) r_state   <= RX_STOP;
              else                   r_bit_idx <= r_bit_idx + 3'd1;
            end else begin
              r_scnt <= r_scnt + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (w_tick) begin
            if (r_scnt == RX_LAST_SAMPLE) begin
              r_scnt <= '0;
              if (w_rx_s) begin
                r_push  <= 1'b1;
                r_state <= RX_IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= RX_BRK;
              end
            end else begin
              r_scnt <= r_scnt + 4'd1;
            end
          end
        end
        // A held-low line must return high before a new start can be seen.
        RX_BRK: begin
          if (w_rx_s) r_state <= RX_IDLE;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign w_pop  = rd_en && !w_empty;
  assign w_drop = r_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst)            r_overflow <= 1'b0;
    else if (w_drop)    r_overflow <= 1'b1;
    else if (clear_err) r_overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_push),
    .din   (r_shift),
    .pop   (rd_en),
    .dout  (rd_data),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign rd_valid  = !w_empty;
  assign rx_busy   = (r_state != RX_IDLE);
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire
